// File: rtl/fine_delay_req_if.sv
//------------------------------------------------------------------------------
// Module  : fine_delay_req_if
// Brief   : valid/ready request channel carrying a total fine-delay tap count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fine_delay_req_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_delay;

    modport master (
        output req_valid,
        output req_delay,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_delay,
        output req_ready
    );
endinterface

`default_nettype wire

// File: rtl/fine_delay_ctrl.sv
//------------------------------------------------------------------------------
// Module  : fine_delay_ctrl
// Brief   : splits a total tap request over three cascaded IDELAYE2 stages,
//           waits for the load to settle and verifies the readback
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fine_delay_ctrl #(
    parameter int TAP_W         = 5,
    parameter int MAX_TAP       = 31,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_RETRY     = 2
) (
    input  wire logic             clk_400,
    input  wire logic             reset_n,
    input  wire logic             idelay_rdy,
    fine_delay_req_if.slave       req,
    output logic [TAP_W-1:0]      fineDelay1,
    output logic [TAP_W-1:0]      fineDelay2,
    output logic [TAP_W-1:0]      fineDelay3,
    input  wire logic [TAP_W-1:0] fineDelay_data1,
    input  wire logic [TAP_W-1:0] fineDelay_data2,
    input  wire logic [TAP_W-1:0] fineDelay_data3,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  clamped,
    output logic [6:0]            delay_applied
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [6:0]       C_MAX_TAP     = 7'(MAX_TAP);
    localparam logic [6:0]       C_MAX_TOTAL   = 7'(3 * MAX_TAP);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] C_MAX_RETRY   = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TAP_W-1:0]   tap1_q, tap1_d, tap2_q, tap2_d, tap3_q, tap3_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               clamped_q, clamped_d;
    logic [6:0]         applied_q, applied_d;

    logic       accept;
    logic       match;
    logic [6:0] total;
    logic [6:0] split1, split2, split3, rem1;
    logic [6:0] readback_sum;

    // Tap split: fill stage 1, then stage 2, remainder lands in stage 3.
    always_comb begin
        total  = (req.req_delay > C_MAX_TOTAL) ? C_MAX_TOTAL : req.req_delay;
        split1 = (total > C_MAX_TAP) ? C_MAX_TAP : total;
        rem1   = total - split1;
        split2 = (rem1 > C_MAX_TAP) ? C_MAX_TAP : rem1;
        split3 = rem1 - split2;
    end

    assign accept       = req.req_valid & req_ready_q & (state_q == S_IDLE);
    assign match        = (fineDelay_data1 == tap1_q) &
                          (fineDelay_data2 == tap2_q) &
                          (fineDelay_data3 == tap3_q);
    assign readback_sum = 7'(fineDelay_data1) + 7'(fineDelay_data2) + 7'(fineDelay_data3);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        tap1_d    = tap1_q;
        tap2_d    = tap2_q;
        tap3_d    = tap3_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        clamped_d = clamped_q;
        applied_d = applied_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SETTLE;
                    cnt_d     = '0;
                    retry_d   = '0;
                    tap1_d    = TAP_W'(split1);
                    tap2_d    = TAP_W'(split2);
                    tap3_d    = TAP_W'(split3);
                    clamped_d = (req.req_delay > C_MAX_TOTAL);
                end
            end
            S_SETTLE: begin
                if (!idelay_rdy) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == C_SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!idelay_rdy) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (match) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    applied_d = readback_sum;
                end else if (retry_q < C_MAX_RETRY) begin
                    // LD is tied high, so simply waiting again reloads the same taps.
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    retry_d = retry_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE) & idelay_rdy;
    end

    always_ff @(posedge clk_400 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            tap1_q      <= '0;
            tap2_q      <= '0;
            tap3_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clamped_q   <= 1'b0;
            applied_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            tap1_q      <= tap1_d;
            tap2_q      <= tap2_d;
            tap3_q      <= tap3_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clamped_q   <= clamped_d;
            applied_q   <= applied_d;
        end
    end

    assign req.req_ready  = req_ready_q;
    assign fineDelay1     = tap1_q;
    assign fineDelay2     = tap2_q;
    assign fineDelay3     = tap3_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign clamped        = clamped_q;
    assign delay_applied  = applied_q;

endmodule

`default_nettype wire

// File: tb/tb_fine_delay_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_fine_delay_ctrl
// Brief   : directed vector bench for fine_delay_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fine_delay_ctrl;

    logic       clk_400 = 1'b0;
    logic       reset_n = 1'b0;
    logic       idelay_rdy = 1'b1;
    logic       stuck2 = 1'b0;
    logic [4:0] fineDelay1, fineDelay2, fineDelay3;
    logic [4:0] fineDelay_data1, fineDelay_data2, fineDelay_data3;
    logic       busy, done, err, clamped;
    logic [6:0] delay_applied;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    fine_delay_req_if req_if ();

    fine_delay_ctrl #(
        .TAP_W(5), .MAX_TAP(31), .SETTLE_CYCLES(8), .MAX_RETRY(2)
    ) dut (
        .clk_400         (clk_400),
        .reset_n         (reset_n),
        .idelay_rdy      (idelay_rdy),
        .req             (req_if.slave),
        .fineDelay1      (fineDelay1),
        .fineDelay2      (fineDelay2),
        .fineDelay3      (fineDelay3),
        .fineDelay_data1 (fineDelay_data1),
        .fineDelay_data2 (fineDelay_data2),
        .fineDelay_data3 (fineDelay_data3),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .clamped         (clamped),
        .delay_applied   (delay_applied)
    );

    // Delay-line model: readback mirrors the loaded taps unless stage 2 is stuck.
    assign fineDelay_data1 = fineDelay1;
    assign fineDelay_data2 = stuck2 ? 5'd5 : fineDelay2;
    assign fineDelay_data3 = fineDelay3;

    always #1.25 clk_400 = ~clk_400;
    always @(posedge clk_400) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] delay;
        logic [4:0] e1, e2, e3;
        logic       e_clamp;
        logic [6:0] e_applied;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk_400);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Presents a request until accepted; returns the accept cycle.
    task automatic do_request(input logic [6:0] d, output int n_acc);
        int budget = 0;
        while (req_if.req_ready !== 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        chk("req_ready_wait", {31'd0, req_if.req_ready}, 1);
        req_if.req_valid = 1'b1;
        req_if.req_delay = d;
        tick();
        n_acc = cyc - 1;
        req_if.req_valid = 1'b0;
        req_if.req_delay = 7'd0;
    endtask

    task automatic wait_end(output int end_cyc, output logic got_done, output logic got_err);
        int budget = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        end_cyc  = -1;
        while (budget < 80) begin
            if (done === 1'b1 || err === 1'b1) begin
                chk("done_err_exclusive", {31'd0, done & err}, 0);
                got_done = done;
                got_err  = err;
                end_cyc  = cyc;
                break;
            end
            tick();
            budget++;
        end
        if (end_cyc < 0) chk("end_timeout", 0, 1);
    endtask

    initial begin
        int   n_acc, end_c;
        logic gd, ge;
        logic [6:0] prev_applied;

        vecs[0] = '{7'd40,  5'd31, 5'd9,  5'd0,  1'b0, 7'd40};
        vecs[1] = '{7'd100, 5'd31, 5'd31, 5'd31, 1'b1, 7'd93};
        vecs[2] = '{7'd93,  5'd31, 5'd31, 5'd31, 1'b0, 7'd93};
        vecs[3] = '{7'd0,   5'd0,  5'd0,  5'd0,  1'b0, 7'd0};
        vecs[4] = '{7'd62,  5'd31, 5'd31, 5'd0,  1'b0, 7'd62};
        vecs[5] = '{7'd32,  5'd31, 5'd1,  5'd0,  1'b0, 7'd32};
        vecs[6] = '{7'd31,  5'd31, 5'd0,  5'd0,  1'b0, 7'd31};
        vecs[7] = '{7'd127, 5'd31, 5'd31, 5'd31, 1'b1, 7'd93};
        vecs[8] = '{7'd94,  5'd31, 5'd31, 5'd31, 1'b1, 7'd93};
        vecs[9] = '{7'd70,  5'd31, 5'd31, 5'd8,  1'b0, 7'd70};

        req_if.req_valid = 1'b0;
        req_if.req_delay = 7'd0;

        // Reset state
        tick(); tick();
        chk("rst_taps", {17'd0, fineDelay1, fineDelay2, fineDelay3}, 0);
        chk("rst_flags", {27'd0, req_if.req_ready, busy, done, err, clamped}, 0);
        chk("rst_applied", {25'd0, delay_applied}, 0);
        reset_n = 1'b1;
        #0.1;
        chk("ready_before_edge", {31'd0, req_if.req_ready}, 0);
        tick();
        chk("ready_after_release", {31'd0, req_if.req_ready}, 1);

        // Main vector table
        for (int i = 0; i < 10; i++) begin
            do_request(vecs[i].delay, n_acc);
            chk($sformatf("v%0d_taps", i), {17'd0, fineDelay1, fineDelay2, fineDelay3},
                {17'd0, vecs[i].e1, vecs[i].e2, vecs[i].e3});
            chk($sformatf("v%0d_clamped", i), {31'd0, clamped}, {31'd0, vecs[i].e_clamp});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 1);
            wait_end(end_c, gd, ge);
            chk($sformatf("v%0d_done", i), {30'd0, gd, ge}, 2);
            chk($sformatf("v%0d_latency", i), end_c - n_acc, 10);
            chk($sformatf("v%0d_applied", i), {25'd0, delay_applied}, {25'd0, vecs[i].e_applied});
            chk($sformatf("v%0d_busy_end", i), {31'd0, busy}, 0);
        end
        prev_applied = 7'd70;

        // Stage 2 readback stuck: three passes then err
        stuck2 = 1'b1;
        do_request(7'd50, n_acc);
        chk("stuck_taps", {17'd0, fineDelay1, fineDelay2, fineDelay3}, {17'd0, 5'd31, 5'd19, 5'd0});
        wait_end(end_c, gd, ge);
        chk("stuck_err", {30'd0, gd, ge}, 1);
        chk("stuck_latency", end_c - n_acc, 28);
        chk("stuck_applied", {25'd0, delay_applied}, {25'd0, prev_applied});
        chk("stuck_busy", {31'd0, busy}, 0);
        tick();
        chk("stuck_err_pulse", {31'd0, err}, 0);
        chk("stuck_taps_held", {17'd0, fineDelay1, fineDelay2, fineDelay3}, {17'd0, 5'd31, 5'd19, 5'd0});
        stuck2 = 1'b0;

        // idelay_rdy dropped at N+4
        do_request(7'd20, n_acc);
        while (cyc < n_acc + 4) tick();
        idelay_rdy = 1'b0;
        wait_end(end_c, gd, ge);
        chk("abort_err", {30'd0, gd, ge}, 1);
        chk("abort_latency", end_c - n_acc, 5);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_ready", {31'd0, req_if.req_ready}, 0);
        chk("abort_applied", {25'd0, delay_applied}, {25'd0, prev_applied});
        chk("abort_taps", {17'd0, fineDelay1, fineDelay2, fineDelay3}, {17'd0, 5'd20, 5'd0, 5'd0});
        tick(); tick(); tick();
        chk("abort_ready_hold", {31'd0, req_if.req_ready}, 0);
        idelay_rdy = 1'b1;
        tick();
        chk("abort_ready_back", {31'd0, req_if.req_ready}, 1);

        // Reset mid-operation
        do_request(7'd60, n_acc);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #0.2;
        chk("midrst_taps", {17'd0, fineDelay1, fineDelay2, fineDelay3}, 0);
        chk("midrst_flags", {27'd0, req_if.req_ready, busy, done, err, clamped}, 0);
        chk("midrst_applied", {25'd0, delay_applied}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        do_request(7'd5, n_acc);
        wait_end(end_c, gd, ge);
        chk("post_rst_done", {30'd0, gd, ge}, 2);
        chk("post_rst_latency", end_c - n_acc, 10);
        chk("post_rst_applied", {25'd0, delay_applied}, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
